// File: rtl/ddls_arb_pkg.sv
// ddls_arb_pkg
//   Shared types and helpers for the DDLS round-robin arbiter.
//   - arb_state_t   : arbiter FSM states
//   - rr_next_grant : first set request bit searching upward from last+1,
//                     modulo n_req (requests padded to MAX_REQ bits)
package ddls_arb_pkg;

    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } arb_state_t;

    // Returns 0 when no request is set; callers qualify with |req.
    function automatic logic [MAX_IDX_W-1:0] rr_next_grant(
        input logic [MAX_REQ-1:0]   req,
        input int                   n_req,
        input logic [MAX_IDX_W-1:0] last
    );
        logic [MAX_IDX_W-1:0] g;
        logic [MAX_IDX_W-1:0] idx3;
        logic                 found;
        int                   idx;
        g     = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx  = (int'(last) + k) % n_req;
            idx3 = MAX_IDX_W'(idx);
            if (!found && (k <= n_req) && req[idx3]) begin
                g     = idx3;
                found = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// rr_grant
//   Combinational round-robin pick.
//   Ports:
//     req_valid [N_REQ]  pending requests
//     last      [IDX_W]  most recently granted index
//     g         [IDX_W]  next grant (meaningful only when any=1)
//     any                at least one request pending
module rr_grant
    import ddls_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] g,
    output logic             any
);

    logic [MAX_REQ-1:0]   req_pad;
    logic [MAX_IDX_W-1:0] last_pad;
    logic [MAX_IDX_W-1:0] g_full;

    assign req_pad  = MAX_REQ'(req_valid);
    assign last_pad = MAX_IDX_W'(last);
    assign g_full   = rr_next_grant(req_pad, N_REQ, last_pad);
    assign g        = IDX_W'(g_full);
    assign any      = |req_valid;

endmodule

// File: rtl/ddls_rr_arbiter.sv
// ddls_rr_arbiter
//   Shares one DDLS Basic-handshake worker between N_REQ requesters with
//   round-robin fairness. One transaction in flight at a time.
//   Optional watchdog: define DDLS_ARB_TIMEOUT_EN to abandon a job after
//   TIMEOUT_CYC wait cycles and answer it with rsp_err=1, rsp_data=0.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     req_valid/req_data per-requester request, held until req_ack
//     req_ack            one-hot pulse, request taken
//     rsp_valid          one-hot pulse to the granted requester
//     rsp_data, rsp_err  result and timeout flag, qualified by rsp_valid
//     wk_valid/wk_data_in  worker start pulse and operand
//     wk_ready/wk_data_out worker idle/result-valid and result
//   All outputs are registered.
module ddls_rr_arbiter
    import ddls_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int RES_W       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ack,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [RES_W-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic                    wk_valid,
    output logic [DATA_W-1:0]       wk_data_in,
    input  logic                    wk_ready,
    input  logic [RES_W-1:0]        wk_data_out
);

    localparam int IDX_W = $clog2(N_REQ);

    generate
        if (N_REQ < 2 || N_REQ > MAX_REQ || TIMEOUT_CYC < 1) begin : g_bad_cfg
            $error("ddls_rr_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
        end
    endgenerate

    arb_state_t          state_q, state_n;
    logic [IDX_W-1:0]    g_q, g_n;
    logic [IDX_W-1:0]    last_q, last_n;
    logic [N_REQ-1:0]    req_ack_q, req_ack_n;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_n;
    logic [RES_W-1:0]    rsp_data_q, rsp_data_n;
    logic                wk_valid_q, wk_valid_n;
    logic [DATA_W-1:0]   wk_data_q, wk_data_n;

    logic [IDX_W-1:0]    pick;
    logic                any;
    logic                issue_ok;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

    rr_grant #(.N_REQ(N_REQ)) u_grant (
        .req_valid (req_valid),
        .last      (last_q),
        .g         (pick),
        .any       (any)
    );

`ifdef DDLS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             rsp_err_q, rsp_err_n;
    logic             timed_out;

    // Counter value k means k wait cycles have already elapsed, so the
    // abort decision is taken in the TIMEOUT_CYC-th wait cycle.
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    // An abandoned job may still be running: hold off until the worker is idle.
    assign issue_ok  = any && wk_ready;
    assign rsp_err   = rsp_err_q;
`else
    assign issue_ok  = any;
    assign rsp_err   = 1'b0;
`endif

    always_comb begin
        state_n     = state_q;
        g_n         = g_q;
        last_n      = last_q;
        req_ack_n   = '0;
        rsp_valid_n = '0;
        rsp_data_n  = '0;
        wk_valid_n  = 1'b0;
        wk_data_n   = wk_data_q;
`ifdef DDLS_ARB_TIMEOUT_EN
        cnt_n       = cnt_q;
        rsp_err_n   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Ack and start are registered here so they show up during ISSUE.
                if (issue_ok) begin
                    g_n        = pick;
                    wk_data_n  = req_data[pick*DATA_W +: DATA_W];
                    req_ack_n  = onehot(pick);
                    wk_valid_n = 1'b1;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                last_n  = g_q;
                state_n = WAIT_BUSY;
`ifdef DDLS_ARB_TIMEOUT_EN
                cnt_n   = '0;
`endif
            end
            WAIT_BUSY: begin
`ifdef DDLS_ARB_TIMEOUT_EN
                cnt_n = cnt_q + CNT_W'(1);
                if (timed_out) begin
                    rsp_valid_n = onehot(g_q);
                    rsp_err_n   = 1'b1;
                    state_n     = RESP;
                end else if (!wk_ready) begin
                    state_n = WAIT_DONE;
                end
`else
                if (!wk_ready) begin
                    state_n = WAIT_DONE;
                end
`endif
            end
            WAIT_DONE: begin
`ifdef DDLS_ARB_TIMEOUT_EN
                cnt_n = cnt_q + CNT_W'(1);
`endif
                // A real result wins over a coincident timeout.
                if (wk_ready) begin
                    rsp_valid_n = onehot(g_q);
                    rsp_data_n  = wk_data_out;
                    state_n     = RESP;
                end
`ifdef DDLS_ARB_TIMEOUT_EN
                else if (timed_out) begin
                    rsp_valid_n = onehot(g_q);
                    rsp_err_n   = 1'b1;
                    state_n     = RESP;
                end
`endif
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            g_q         <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            req_ack_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            wk_valid_q  <= 1'b0;
            wk_data_q   <= '0;
        end else begin
            state_q     <= state_n;
            g_q         <= g_n;
            last_q      <= last_n;
            req_ack_q   <= req_ack_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_data_q  <= rsp_data_n;
            wk_valid_q  <= wk_valid_n;
            wk_data_q   <= wk_data_n;
        end
    end

`ifdef DDLS_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_n;
            rsp_err_q <= rsp_err_n;
        end
    end
`endif

    assign req_ack    = req_ack_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign wk_valid   = wk_valid_q;
    assign wk_data_in = wk_data_q;

endmodule

// File: tb/tb_ddls_rr_arbiter.sv
// Testbench for ddls_rr_arbiter: vector table, directed corner sequences,
// and randomized traffic checked against a round-robin reference model.
module tb_ddls_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int RW = 4;
`ifdef DDLS_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    rsp_valid;
    logic [RW-1:0]   rsp_data;
    logic            rsp_err;
    logic            wk_valid;
    logic [DW-1:0]   wk_data_in;
    logic            wk_ready;
    logic [RW-1:0]   wk_data_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddls_rr_arbiter #(
        .N_REQ(N), .DATA_W(DW), .RES_W(RW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .wk_valid(wk_valid), .wk_data_in(wk_data_in),
        .wk_ready(wk_ready), .wk_data_out(wk_data_out)
    );

    // Bit-counter worker: accepts on wk_valid, busy for busy_len+1 cycles.
    int busy_len = 0;
    bit stall    = 1'b0;
    int wk_cnt;
    always @(posedge clk) begin
        if (rst) begin
            wk_ready    <= 1'b1;
            wk_cnt      <= 0;
            wk_data_out <= '0;
        end else if (wk_ready) begin
            if (wk_valid && !stall) begin
                wk_ready    <= 1'b0;
                wk_cnt      <= busy_len;
                wk_data_out <= RW'($countones(wk_data_in));
            end
        end else if (wk_cnt == 0) begin
            wk_ready <= 1'b1;
        end else begin
            wk_cnt <= wk_cnt - 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ref_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[2'((last + k) % N)]) return (last + k) % N;
        return -1;
    endfunction

    task automatic wait_ack(output int c, output int a, output int wv, output int wd);
        c = -1; a = 0; wv = 0; wd = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ack != 0) begin
                c = cyc; a = int'(req_ack); wv = int'(wk_valid); wd = int'(wk_data_in);
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int c, output int v, output int d, output int e);
        c = -1; v = 0; d = -1; e = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (rsp_valid != 0) begin
                c = cyc; v = int'(rsp_valid); d = int'(rsp_data); e = int'(rsp_err);
                break;
            end
        end
    endtask

    task automatic chk_outs_zero(input string nm);
        chk({nm, "_req_ack"}, int'(req_ack), 0);
        chk({nm, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({nm, "_rsp_data"}, int'(rsp_data), 0);
        chk({nm, "_rsp_err"}, int'(rsp_err), 0);
        chk({nm, "_wk_valid"}, int'(wk_valid), 0);
        chk({nm, "_wk_data_in"}, int'(wk_data_in), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_outs_zero("reset");
        rst = 1'b0;
    endtask

    // Random traffic. In fair mode lane 2 is always requesting, lanes 0 and 3
    // come and go, lane 1 stays quiet.
    task automatic rand_phase(input bit fair, input int ncyc);
        int m_last = N - 1;
        int out_g  = -1;
        int out_res = 0;
        int waits[N];
        int ntx = 0;
        int eg;
        bit raise;
        do_reset();
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            if (req_ack != 0) begin
                eg = ref_pick(req_valid, m_last);
                chk("rnd_grant", int'(req_ack), (eg < 0) ? 0 : (1 << eg));
                chk("rnd_wk_valid", int'(wk_valid), 1);
                chk("rnd_one_in_flight", out_g, -1);
                if (eg >= 0) begin
                    for (int i = 0; i < N; i++) begin
                        if (i != eg && req_valid[2'(i)]) begin
                            waits[i]++;
                            chk("rnd_fair_wait", int'(waits[i] <= N - 1), 1);
                        end
                    end
                    waits[eg] = 0;
                    out_g     = eg;
                    out_res   = $countones(req_data[eg*DW +: DW]);
                    m_last    = eg;
                    req_valid[2'(eg)] = 1'b0;
                end
            end else if (wk_valid) begin
                chk("rnd_wk_valid_alone", int'(wk_valid), 0);
            end
            if (rsp_valid != 0) begin
                chk("rnd_rsp_dst", int'(rsp_valid), (out_g < 0) ? 0 : (1 << out_g));
                chk("rnd_rsp_data", int'(rsp_data), out_res);
                chk("rnd_rsp_err", int'(rsp_err), 0);
                out_g = -1;
                ntx++;
            end
            busy_len = $urandom_range(0, 4);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[2'(i)]) begin
                    if (fair) raise = (i == 2) || (i != 1 && $urandom_range(0, 1) == 1);
                    else      raise = ($urandom_range(0, 2) == 0);
                    if (raise) begin
                        req_valid[2'(i)]      = 1'b1;
                        req_data[i*DW +: DW] = DW'($urandom);
                        waits[i]             = 0;
                    end
                end
            end
        end
        chk("rnd_progress", int'(ntx >= 40), 1);
    endtask

    typedef struct {
        logic [N-1:0]    mask;
        logic [N*DW-1:0] data;
        int              g;
        int              res;
    } vec_t;

    vec_t vt[9];

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c, a, wv, wd, v, d, e, p0, c1;
        bit seen;

        // Rows chain: 'last' carries over from the previous row (reset -> 3).
        vt[0] = '{4'b0001, 32'h000000FF, 0, 8};
        vt[1] = '{4'b1001, 32'h3C000000, 3, 4};
        vt[2] = '{4'b1001, 32'h3C000000, 0, 0};
        vt[3] = '{4'b0100, 32'h00FF0000, 2, 8};
        vt[4] = '{4'b0011, 32'h00007F81, 0, 2};
        vt[5] = '{4'b0110, 32'h00557F00, 1, 7};
        vt[6] = '{4'b0010, 32'h00000100, 1, 1};
        vt[7] = '{4'b1100, 32'hF0550000, 2, 4};
        vt[8] = '{4'b1100, 32'hF0550000, 3, 4};

        do_reset();
        for (int r = 0; r < 9; r++) begin
            busy_len  = r % 3;
            req_data  = vt[r].data;
            req_valid = vt[r].mask;
            wait_ack(c, a, wv, wd);
            chk("tbl_ack", a, 1 << vt[r].g);
            chk("tbl_wk_valid", wv, 1);
            chk("tbl_wk_data", wd, int'(vt[r].data[vt[r].g*DW +: DW]));
            req_valid = '0;
            wait_rsp(c, v, d, e);
            chk("tbl_rsp_dst", v, 1 << vt[r].g);
            chk("tbl_rsp_data", d, vt[r].res);
            chk("tbl_rsp_err", e, 0);
        end

        // Full contention: all four held, grants rotate 0,1,2,3,0.
        do_reset();
        busy_len  = 1;
        req_data  = 32'h0F070301;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(c, a, wv, wd);
            chk("cont_ack", a, 1 << (k % 4));
            wait_rsp(c, v, d, e);
            chk("cont_rsp_dst", v, 1 << (k % 4));
            chk("cont_rsp_data", d, (k % 4) + 1);
        end
        req_valid = '0;

        // Minimum latency with a second request queued behind.
        do_reset();
        busy_len  = 0;
        req_data  = 32'h0000030F;
        req_valid = 4'b0011;
        p0 = cyc;
        wait_ack(c, a, wv, wd);
        chk("lat_ack_cyc", c - p0, 1);
        chk("lat_ack0", a, 1);
        req_valid[0] = 1'b0;
        wait_rsp(c, v, d, e);
        chk("lat_rsp_cyc", c - p0, 4);
        chk("lat_rsp_data", d, 4);
        wait_ack(c, a, wv, wd);
        chk("lat_ack2_cyc", c - p0, 6);
        chk("lat_ack1", a, 2);
        req_valid = '0;
        wait_rsp(c, v, d, e);
        chk("lat_rsp2_data", d, 2);

        // Reset while waiting for the worker.
        do_reset();
        busy_len  = 5;
        req_data  = 32'h00000300;
        req_valid = 4'b0010;
        wait_ack(c, a, wv, wd);
        chk("rstmid_ack", a, 2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_outs_zero("rstmid");
        rst = 1'b0;
        req_data  = 32'h00000307;
        req_valid = 4'b0011;
        seen = 1'b0;
        a = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid != 0) seen = 1'b1;
            if (req_ack != 0) begin a = int'(req_ack); break; end
        end
        chk("rstmid_no_rsp", int'(seen), 0);
        chk("rstmid_first_grant", a, 1);
        req_valid = '0;
        wait_rsp(c, v, d, e);
        chk("rstmid_rsp_data", d, 3);

`ifdef DDLS_ARB_TIMEOUT_EN
        // Worker never accepts: watchdog answers with an error.
        do_reset();
        stall     = 1'b1;
        req_data  = 32'h000000AA;
        req_valid = 4'b0001;
        wait_ack(c1, a, wv, wd);
        req_valid = '0;
        wait_rsp(c, v, d, e);
        chk("to_latency", c - c1, TO + 1);
        chk("to_rsp_dst", v, 1);
        chk("to_rsp_err", e, 1);
        chk("to_rsp_data", d, 0);
        stall     = 1'b0;
        req_data  = 32'h00000300;
        req_valid = 4'b0010;
        wait_ack(c, a, wv, wd);
        chk("to_next_ack", a, 2);
        req_valid = '0;
        wait_rsp(c, v, d, e);
        chk("to_next_data", d, 2);
        chk("to_next_err", e, 0);
`endif

        rand_phase(1'b0, 1500);
        rand_phase(1'b1, 1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
